pdm_sigma_delta_tx: RTL and testbench

Second-order sigma-delta modulator: the transmit/DAC-side counterpart of the `dlpf` decimation path. It accepts signed 16-bit PCM samples through a valid/ready handshake, holds each one for OSR clock cycles, and emits a 1-bit pulse-density stream. The stream is intended for an external analog reconstruction filter, or for a loopback through the `dlpf` receive chain.

---
 rtl/pdm_sigma_delta_tx.sv | 130 +++++++++++++
 tb/tb_pdm_sigma_delta_tx.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_sigma_delta_tx.sv
// pdm_sigma_delta_tx: second-order sigma-delta modulator that turns signed PCM
// samples into a 1-bit pulse-density stream. Each sample is taken through a
// one-entry buffer and held for OSR enabled cycles.
// Optional build macro PDM_DITHER_EN adds a 16-bit LFSR dither, in the range
// -4..+3, at the quantizer input.
module pdm_sigma_delta_tx #(
   parameter int DATA_W = 16,
   parameter int OSR    = 64,
   parameter int ACC_W  = 24
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable,
   input  logic signed [DATA_W-1:0] sample_in,
   input  logic                     sample_valid,
   output logic                     sample_ready,
   output logic                     pdm_out,
   output logic                     sample_tick,
   output logic                     underrun,
   input  logic                     underrun_clr
);

   localparam int PH_W  = $clog2(OSR);
   // Two guard bits hold acc + x - fb without overflow before saturation.
   localparam int EXT_W = ACC_W + 2;
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(OSR - 1);
   localparam logic signed [EXT_W-1:0] ACC_MAX = {3'b000, {(ACC_W-1){1'b1}}};
   localparam logic signed [EXT_W-1:0] ACC_MIN = {3'b111, {(ACC_W-1){1'b0}}};
   localparam logic signed [EXT_W-1:0] FB_POS  =
      {{(EXT_W-DATA_W){1'b0}}, 1'b1, {(DATA_W-1){1'b0}}};
   localparam logic signed [EXT_W-1:0] FB_NEG  =
      {{(EXT_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   function automatic logic signed [ACC_W-1:0] sat(input logic signed [EXT_W-1:0] v);
      logic signed [EXT_W-1:0] c;
      if (v > ACC_MAX)      c = ACC_MAX;
      else if (v < ACC_MIN) c = ACC_MIN;
      else                  c = v;
      return c[ACC_W-1:0];
   endfunction

   logic [PH_W-1:0]          phase_q, phase_d;
   logic signed [DATA_W-1:0] buf_q;
   logic                     buf_full_q;
   logic signed [DATA_W-1:0] hold_q;
   logic signed [ACC_W-1:0]  acc1_q, acc1_d;
   logic signed [ACC_W-1:0]  acc2_q, acc2_d;
   logic                     pdm_q, pdm_d;
   logic                     tick_q;
   logic                     und_q;
   logic                     reload;
   logic signed [EXT_W-1:0]  fb, x_ext, sum1, sum2;
   logic signed [EXT_W-1:0]  q_ext;

   assign reload       = enable && (phase_q == PH_LAST);
   assign sample_ready = ~buf_full_q;
   assign pdm_out      = pdm_q;
   assign sample_tick  = tick_q;
   assign underrun     = und_q;

`ifdef PDM_DITHER_EN
   logic [15:0]             lfsr_q;
   logic signed [EXT_W-1:0] dith;

   // Dither source: Fibonacci LFSR (taps 16,14,13,11), advances on enabled cycles.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        lfsr_q <= 16'hACE1;
      else if (enable) lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end

   assign dith = {{(EXT_W-3){lfsr_q[2]}}, lfsr_q[2:0]};
`endif

   // Modulator next state: two saturating integrators and the sign quantizer.
   always_comb begin
      phase_d = reload ? '0 : phase_q + PH_W'(1);
      fb      = pdm_q ? FB_POS : FB_NEG;
      x_ext   = {{(EXT_W-DATA_W){hold_q[DATA_W-1]}}, hold_q};
      sum1    = {{2{acc1_q[ACC_W-1]}}, acc1_q} + x_ext - fb;
      acc1_d  = sat(sum1);
      sum2    = {{2{acc2_q[ACC_W-1]}}, acc2_q} + {{2{acc1_d[ACC_W-1]}}, acc1_d} - fb;
      acc2_d  = sat(sum2);
`ifdef PDM_DITHER_EN
      q_ext   = {{2{acc2_d[ACC_W-1]}}, acc2_d} + dith;
`else
      q_ext   = {{2{acc2_d[ACC_W-1]}}, acc2_d};
`endif
      pdm_d   = ~q_ext[EXT_W-1];
   end

   // Modulator core registers; everything freezes while enable is low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase_q <= '0;
         acc1_q  <= '0;
         acc2_q  <= '0;
         pdm_q   <= 1'b0;
      end else if (enable) begin
         phase_q <= phase_d;
         acc1_q  <= acc1_d;
         acc2_q  <= acc2_d;
         pdm_q   <= pdm_d;
      end
   end

   // Input buffer, hold register, reload strobe and sticky underrun flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         buf_q      <= '0;
         buf_full_q <= 1'b0;
         hold_q     <= '0;
         tick_q     <= 1'b0;
         und_q      <= 1'b0;
      end else begin
         tick_q <= reload;
         // A reload drains a full buffer; an empty buffer may still accept on
         // the reload edge, and that sample waits for the next reload.
         if (reload && buf_full_q) begin
            hold_q     <= buf_q;
            buf_full_q <= 1'b0;
         end else if (sample_valid && !buf_full_q) begin
            buf_q      <= sample_in;
            buf_full_q <= 1'b1;
         end
         if (underrun_clr)               und_q <= 1'b0;
         else if (reload && !buf_full_q) und_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pdm_sigma_delta_tx.sv
// Directed bench for pdm_sigma_delta_tx (default build, no dither).
module tb_pdm_sigma_delta_tx;
   localparam int DATA_W = 16;
   localparam int OSR    = 64;
   localparam int ACC_W  = 24;

   logic                     clk = 1'b0;
   logic                     rst = 1'b0;
   logic                     enable = 1'b0;
   logic signed [DATA_W-1:0] sample_in = '0;
   logic                     sample_valid = 1'b0;
   logic                     sample_ready;
   logic                     pdm_out;
   logic                     sample_tick;
   logic                     underrun;
   logic                     underrun_clr = 1'b0;

   always #5 clk = ~clk;

   pdm_sigma_delta_tx #(.DATA_W(DATA_W), .OSR(OSR), .ACC_W(ACC_W)) dut (
      .clk(clk), .rst(rst), .enable(enable), .sample_in(sample_in),
      .sample_valid(sample_valid), .sample_ready(sample_ready),
      .pdm_out(pdm_out), .sample_tick(sample_tick), .underrun(underrun),
      .underrun_clr(underrun_clr)
   );

   int checks = 0;
   int failures = 0;
   int seg_mis = 0;

   // Reference model of the modulator and handshake, integer arithmetic.
   int m_phase = 0, m_acc1 = 0, m_acc2 = 0, m_hold = 0, m_buf = 0, m_fb, n_a1, n_a2;
   bit m_pdm = 0, m_full = 0, m_tick = 0, m_und = 0, n_pdm, m_reload;

   function automatic int msat(input int v);
      if (v > 8388607)  return 8388607;
      if (v < -8388608) return -8388608;
      return v;
   endfunction

   always_comb begin
      m_fb     = m_pdm ? 32768 : -32768;
      n_a1     = msat(m_acc1 + m_hold - m_fb);
      n_a2     = msat(m_acc2 + n_a1 - m_fb);
      n_pdm    = (n_a2 >= 0);
      m_reload = enable && (m_phase == OSR - 1);
   end

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_phase <= 0; m_acc1 <= 0; m_acc2 <= 0; m_pdm <= 0;
         m_hold <= 0; m_buf <= 0; m_full <= 0; m_tick <= 0; m_und <= 0;
      end else begin
         m_tick <= m_reload;
         if (enable) begin
            m_phase <= m_reload ? 0 : m_phase + 1;
            m_acc1  <= n_a1;
            m_acc2  <= n_a2;
            m_pdm   <= n_pdm;
         end
         if (m_reload && m_full) begin
            m_hold <= m_buf;
            m_full <= 0;
         end else if (sample_valid && !m_full) begin
            m_buf  <= int'(sample_in);
            m_full <= 1;
         end
         if (underrun_clr)            m_und <= 0;
         else if (m_reload && !m_full) m_und <= 1;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic chk_rng(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
      end
   endtask

   // One clock: inputs were set before the rising edge, outputs sampled on the falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
      if (pdm_out !== m_pdm || sample_tick !== m_tick ||
          sample_ready !== !m_full || underrun !== m_und)
         seg_mis++;
   endtask

   task automatic seg_check(input string name);
      chk(name, seg_mis, 0);
      seg_mis = 0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      step();
      step();
      rst = 1'b1;
   endtask

   typedef struct {
      logic signed [DATA_W-1:0] x;
      int lo;
      int hi;
   } dc_vec_t;

   dc_vec_t dc_tab [5];
   int ones, xfer, ticks, ready_hi, frz_bad;
   int c_pdm, c_phase, c_a1, c_a2;

   initial begin
      dc_tab[0] = '{16'sh0000, 31, 33};
      dc_tab[1] = '{16'sh4000, 46, 50};
      dc_tab[2] = '{16'shC000, 14, 18};
      dc_tab[3] = '{16'sh2000, 38, 42};
      dc_tab[4] = '{16'shE000, 22, 26};

      // Reset state
      step();
      chk("rst_pdm", int'(pdm_out), 0);
      chk("rst_ready", int'(sample_ready), 1);
      chk("rst_tick", int'(sample_tick), 0);
      chk("rst_underrun", int'(underrun), 0);
      seg_mis = 0;

      // DC density table
      for (int i = 0; i < 5; i++) begin
         do_reset();
         enable = 1'b1;
         sample_valid = 1'b1;
         sample_in = dc_tab[i].x;
         for (int k = 0; k < 64 + 128; k++) step();
         ones = 0;
         for (int k = 0; k < 64; k++) begin
            step();
            if (pdm_out) ones++;
         end
         chk_rng($sformatf("dc_ones_%0d", i), ones, dc_tab[i].lo, dc_tab[i].hi);
         seg_check($sformatf("dc_stream_%0d", i));
      end

      // Handshake: one transfer per reload, samples applied in order
      do_reset();
      enable = 1'b1;
      sample_valid = 1'b1;
      sample_in = 16'sh0100;
      step();
      chk("hs_ready_fall", int'(sample_ready), 0);
      sample_in = 16'sh0200;
      ready_hi = 0;
      ticks = 0;
      for (int k = 0; k < 62; k++) begin
         step();
         if (sample_ready) ready_hi++;
         if (sample_tick) ticks++;
      end
      chk("hs_ready_low_between", ready_hi, 0);
      chk("hs_no_early_tick", ticks, 0);
      step();
      chk("hs_tick", int'(sample_tick), 1);
      chk("hs_ready_rise", int'(sample_ready), 1);
      chk("hs_hold1", int'(dut.hold_q), 16'h0100);
      xfer = 0;
      ticks = 0;
      for (int k = 0; k < 128; k++) begin
         if (sample_valid && sample_ready) xfer++;
         step();
         if (sample_tick) ticks++;
         if (k == 0) sample_in = 16'sh0300;
         if (k == 63) begin
            chk("hs_tick2", int'(sample_tick), 1);
            chk("hs_hold2", int'(dut.hold_q), 16'h0200);
         end
      end
      chk("hs_xfers", xfer, 2);
      chk("hs_ticks", ticks, 2);
      chk("hs_hold3", int'(dut.hold_q), 16'h0300);
      seg_check("hs_stream");

      // Underrun: stop feeding, flag sets, hold keeps last value
      sample_valid = 1'b0;
      for (int k = 0; k < 63; k++) step();
      chk("ur_before", int'(underrun), 0);
      step();
      chk("ur_set", int'(underrun), 1);
      chk("ur_tick", int'(sample_tick), 1);
      chk("ur_hold_kept", int'(dut.hold_q), 16'h0300);
      for (int k = 0; k < 63; k++) step();
      underrun_clr = 1'b1;
      step();
      underrun_clr = 1'b0;
      chk("ur_clr_priority", int'(underrun), 0);
      for (int k = 0; k < 64; k++) step();
      chk("ur_set_again", int'(underrun), 1);
      // No bypass: sample accepted on an empty-buffer reload waits a period
      for (int k = 0; k < 63; k++) step();
      sample_valid = 1'b1;
      sample_in = 16'sh0500;
      step();
      sample_valid = 1'b0;
      chk("nb_hold_unchanged", int'(dut.hold_q), 16'h0300);
      chk("nb_buffered", int'(sample_ready), 0);
      for (int k = 0; k < 64; k++) step();
      chk("nb_next_reload", int'(dut.hold_q), 16'h0500);
      seg_check("ur_stream");

      // Enable freeze mid-period
      for (int k = 0; k < 20; k++) step();
      c_pdm = int'(pdm_out);
      c_phase = int'(dut.phase_q);
      c_a1 = int'(dut.acc1_q);
      c_a2 = int'(dut.acc2_q);
      enable = 1'b0;
      frz_bad = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (int'(pdm_out) != c_pdm || int'(dut.phase_q) != c_phase ||
             int'(dut.acc1_q) != c_a1 || int'(dut.acc2_q) != c_a2 || sample_tick)
            frz_bad++;
      end
      chk("frz_hold", frz_bad, 0);
      enable = 1'b1;
      for (int k = 0; k < 150; k++) step();
      seg_check("frz_stream");

      // Reset mid-operation discards a buffered sample
      sample_valid = 1'b1;
      sample_in = 16'sh0700;
      step();
      sample_valid = 1'b0;
      chk("mr_buffered", int'(sample_ready), 0);
      rst = 1'b0;
      #1;
      chk("mr_pdm", int'(pdm_out), 0);
      chk("mr_ready", int'(sample_ready), 1);
      chk("mr_tick", int'(sample_tick), 0);
      chk("mr_underrun", int'(underrun), 0);
      step();
      rst = 1'b1;
      chk("mr_phase0", int'(dut.phase_q), 0);
      step();
      chk("mr_phase1", int'(dut.phase_q), 1);
      chk("mr_ready_after", int'(sample_ready), 1);
      for (int k = 0; k < 63; k++) step();
      chk("mr_underrun_empty", int'(underrun), 1);
      chk("mr_hold_zero", int'(dut.hold_q), 0);
      seg_check("mr_stream");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
